// File: rtl/piso_crc_buffer_pkg.sv
// Shared types and constants for the PISO frame buffer with optional CRC-16 trailer.
// The CRC trailer is built only when PISO_CRC_APPEND_EN is defined.
package piso_crc_buffer_pkg;

    localparam int unsigned DATA_BYTES_DEF = 16;
    localparam int unsigned CRC_BYTES      = 2;
    localparam int unsigned FRAME_LEN_DEF  = DATA_BYTES_DEF + CRC_BYTES;
    localparam logic [15:0] CRC_POLY_DEF   = 16'h1021;
    localparam logic [15:0] CRC_INIT_DEF   = 16'hFFFF;

`ifdef PISO_CRC_APPEND_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2,
        EMPTY = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd2,
        EMPTY = 2'd3
    } state_e;
`endif

    // Frame length in bytes for a payload of data_bytes, with or without the CRC trailer.
    function automatic int unsigned frame_len(input int unsigned data_bytes, input logic with_crc);
        return with_crc ? data_bytes + CRC_BYTES : data_bytes;
    endfunction

endpackage

// File: rtl/piso_crc_buffer_crc16_byte_step.sv
// One-byte CRC-16 update, MSB-first, no reflection; purely combinational.
module crc16_byte_step
    import piso_crc_buffer_pkg::*;
#(
    parameter logic [15:0] POLY = CRC_POLY_DEF
) (
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {byte_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/piso_crc_buffer.sv
// Byte-wide parallel-in/serial-out frame buffer feeding a UART data register.
// Define PISO_CRC_APPEND_EN to compute and append a CRC-16 trailer (CALC state).
module piso_crc_buffer
    import piso_crc_buffer_pkg::*;
#(
    parameter int unsigned DATA_BYTES = DATA_BYTES_DEF,
    parameter logic [15:0] CRC_POLY   = CRC_POLY_DEF,
    parameter logic [15:0] CRC_INIT   = CRC_INIT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      PISO_reset,
    input  logic                      PISO_load,
    input  logic                      en_crc,
    input  logic                      hold,
    input  logic [8*DATA_BYTES-1:0]   data_in,
    output logic [7:0]                byte_out,
    output logic                      byte_valid,
    output logic                      PISO_empty,
    output logic                      busy,
    output logic [15:0]               crc_out
);

    localparam int unsigned FRAME_LEN = frame_len(DATA_BYTES, 1'b1);
    localparam int unsigned PTR_W     = $clog2(FRAME_LEN + 1);

    state_e                    state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [8*DATA_BYTES-1:0]   data_q, data_d;
    logic [7:0]                byte_out_q, byte_out_d;
    logic                      byte_valid_q, byte_valid_d;
    logic                      empty_q, empty_d;

    logic [7:0]                pay_byte_c;
    logic                      pop_ok_c;
    logic [7:0]                pop_byte_c;
    logic [PTR_W-1:0]          last_ptr_c;
    logic                      pop_state_c;

    // Payload byte addressed by the read pointer (byte 0 at the MSB end).
    always_comb begin
        pay_byte_c = 8'h00;
        for (int k = 0; k < int'(DATA_BYTES); k++) begin
            if (ptr_q == PTR_W'(k)) pay_byte_c = data_q[8*(int'(DATA_BYTES)-1-k) +: 8];
        end
    end

`ifdef PISO_CRC_APPEND_EN
    localparam int unsigned IDX_W = $clog2(DATA_BYTES);

    logic                      busy_q, busy_d;
    logic [15:0]               crc_out_q, crc_out_d;
    logic [15:0]               crc_acc_q, crc_acc_d;
    logic [IDX_W-1:0]          calc_idx_q, calc_idx_d;
    logic                      with_crc_q, with_crc_d;
    logic [7:0]                calc_byte_c;
    logic [15:0]               crc_step_c;

    always_comb begin
        calc_byte_c = 8'h00;
        for (int k = 0; k < int'(DATA_BYTES); k++) begin
            if (calc_idx_q == IDX_W'(k)) calc_byte_c = data_q[8*(int'(DATA_BYTES)-1-k) +: 8];
        end
    end

    crc16_byte_step #(
        .POLY (CRC_POLY)
    ) u_crc_step (
        .crc_in  (crc_acc_q),
        .byte_in (calc_byte_c),
        .crc_out (crc_step_c)
    );

    // CRC trailer bytes only become poppable once the CRC is final.
    always_comb begin
        pop_ok_c    = 1'b0;
        pop_byte_c  = pay_byte_c;
        pop_state_c = (state_q == CALC) || (state_q == SHIFT);
        last_ptr_c  = with_crc_q ? PTR_W'(FRAME_LEN - 1) : PTR_W'(DATA_BYTES - 1);
        if (ptr_q < PTR_W'(DATA_BYTES)) begin
            pop_ok_c = 1'b1;
        end else if (!busy_q) begin
            pop_ok_c   = 1'b1;
            pop_byte_c = (ptr_q == PTR_W'(DATA_BYTES)) ? crc_out_q[15:8] : crc_out_q[7:0];
        end
    end

    assign busy    = busy_q;
    assign crc_out = crc_out_q;
`else
    logic unused_cfg;

    always_comb begin
        pop_ok_c    = 1'b1;
        pop_byte_c  = pay_byte_c;
        pop_state_c = (state_q == SHIFT);
        last_ptr_c  = PTR_W'(DATA_BYTES - 1);
    end

    assign unused_cfg = ^{en_crc, CRC_POLY, CRC_INIT};
    assign busy       = 1'b0;
    assign crc_out    = 16'h0000;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        data_d       = data_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        empty_d      = empty_q;
`ifdef PISO_CRC_APPEND_EN
        busy_d       = busy_q;
        crc_out_d    = crc_out_q;
        crc_acc_d    = crc_acc_q;
        calc_idx_d   = calc_idx_q;
        with_crc_d   = with_crc_q;
`endif
        if (PISO_reset) begin
            state_d      = IDLE;
            ptr_d        = '0;
            byte_out_d   = 8'h00;
            byte_valid_d = 1'b0;
            empty_d      = 1'b1;
`ifdef PISO_CRC_APPEND_EN
            busy_d       = 1'b0;
            crc_out_d    = 16'h0000;
            calc_idx_d   = '0;
            with_crc_d   = 1'b0;
`endif
        end else if (PISO_load) begin
            data_d       = data_in;
            ptr_d        = '0;
            byte_valid_d = 1'b0;
            empty_d      = 1'b0;
`ifdef PISO_CRC_APPEND_EN
            crc_out_d    = 16'h0000;
            crc_acc_d    = CRC_INIT;
            calc_idx_d   = '0;
            with_crc_d   = en_crc;
            busy_d       = en_crc;
            state_d      = en_crc ? CALC : SHIFT;
`else
            state_d      = SHIFT;
`endif
        end else begin
`ifdef PISO_CRC_APPEND_EN
            if (state_q == CALC) begin
                crc_acc_d = crc_step_c;
                if (calc_idx_q == IDX_W'(DATA_BYTES - 1)) begin
                    crc_out_d = crc_step_c;
                    busy_d    = 1'b0;
                    state_d   = SHIFT;
                end else begin
                    calc_idx_d = calc_idx_q + IDX_W'(1);
                end
            end
`endif
            if (!hold && pop_state_c && pop_ok_c) begin
                byte_out_d   = pop_byte_c;
                byte_valid_d = 1'b1;
                ptr_d        = ptr_q + PTR_W'(1);
                if (ptr_q == last_ptr_c) begin
                    state_d = EMPTY;
                    empty_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            data_q       <= '0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            empty_q      <= 1'b1;
`ifdef PISO_CRC_APPEND_EN
            busy_q       <= 1'b0;
            crc_out_q    <= 16'h0000;
            crc_acc_q    <= 16'h0000;
            calc_idx_q   <= '0;
            with_crc_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            data_q       <= data_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            empty_q      <= empty_d;
`ifdef PISO_CRC_APPEND_EN
            busy_q       <= busy_d;
            crc_out_q    <= crc_out_d;
            crc_acc_q    <= crc_acc_d;
            calc_idx_q   <= calc_idx_d;
            with_crc_q   <= with_crc_d;
`endif
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign PISO_empty = empty_q;

endmodule

// File: tb/tb_piso_crc_buffer.sv
// Directed bench for piso_crc_buffer: a 16-byte and a 9-byte instance share the controls.
// CRC trailer scenarios are compiled in when PISO_CRC_APPEND_EN is defined.
module tb_piso_crc_buffer;

    logic         clk = 1'b0;
    logic         reset, piso_reset, piso_load, en_crc, hold;
    logic [127:0] data16;
    logic [71:0]  data9;

    logic [7:0]   byte16, byte9;
    logic         valid16, valid9, empty16, empty9, busy16, busy9;
    logic [15:0]  crc16, crc9;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    piso_crc_buffer #(.DATA_BYTES(16)) u_dut16 (
        .clk        (clk),
        .reset      (reset),
        .PISO_reset (piso_reset),
        .PISO_load  (piso_load),
        .en_crc     (en_crc),
        .hold       (hold),
        .data_in    (data16),
        .byte_out   (byte16),
        .byte_valid (valid16),
        .PISO_empty (empty16),
        .busy       (busy16),
        .crc_out    (crc16)
    );

    piso_crc_buffer #(.DATA_BYTES(9)) u_dut9 (
        .clk        (clk),
        .reset      (reset),
        .PISO_reset (piso_reset),
        .PISO_load  (piso_load),
        .en_crc     (en_crc),
        .hold       (hold),
        .data_in    (data9),
        .byte_out   (byte9),
        .byte_valid (valid9),
        .PISO_empty (empty9),
        .busy       (busy9),
        .crc_out    (crc9)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic chk_reset16(input string tag);
        chk({tag, "_byte"},  32'(byte16),  32'h00);
        chk({tag, "_valid"}, 32'(valid16), 32'h0);
        chk({tag, "_empty"}, 32'(empty16), 32'h1);
        chk({tag, "_busy"},  32'(busy16),  32'h0);
        chk({tag, "_crc"},   32'(crc16),   32'h0);
    endtask

    task automatic load(input logic crc);
        en_crc    = crc;
        piso_load = 1'b1;
        tick();
        piso_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; piso_reset = 1'b0; piso_load = 1'b0; en_crc = 1'b0; hold = 1'b1;
        data16 = 128'h000102030405060708090A0B0C0D0E0F;
        data9  = 72'h313233343536373839;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_reset16("rst");

        // 16-byte frame without CRC, plus one extra pop after the end
        load(1'b0);
        chk("a_empty_after_load", 32'(empty16), 32'h0);
        chk("a_valid_after_load", 32'(valid16), 32'h0);
        hold = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("a_byte",  32'(byte16),  32'(i));
            chk("a_valid", 32'(valid16), 32'h1);
            chk("a_empty", 32'(empty16), (i == 15) ? 32'h1 : 32'h0);
        end
        tick();
        chk("a_extra_pop_byte",  32'(byte16),  32'h0F);
        chk("a_extra_pop_empty", 32'(empty16), 32'h1);
        hold = 1'b1;

        // Reload after 5 pops restarts at byte 0 of the new data
        load(1'b0);
        hold = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("b_fifth_pop", 32'(byte16), 32'h04);
        data16    = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
        piso_load = 1'b1;
        tick();
        piso_load = 1'b0;
        chk("b_reload_valid", 32'(valid16), 32'h0);
        chk("b_reload_empty", 32'(empty16), 32'h0);
        tick();
        chk("b_new_byte0", 32'(byte16), 32'hF0);
        tick();
        chk("b_new_byte1", 32'(byte16), 32'hF1);
        hold = 1'b1;

        // PISO_reset mid-SHIFT, then pops in IDLE are ignored
        piso_reset = 1'b1;
        tick();
        piso_reset = 1'b0;
        chk_reset16("c_piso_reset");
        hold = 1'b0;
        tick();
        chk("c_idle_pop_byte",  32'(byte16),  32'h00);
        chk("c_idle_pop_valid", 32'(valid16), 32'h0);
        hold = 1'b1;

        // Global reset mid-SHIFT
        load(1'b0);
        hold = 1'b0;
        tick(); tick();
        chk("d_pop1", 32'(byte16), 32'hF1);
        reset = 1'b1; hold = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset16("d_reset");

        // PISO_reset wins over a simultaneous PISO_load
        load(1'b0);
        hold = 1'b0;
        tick();
        chk("e_pop0", 32'(byte16), 32'hF0);
        piso_reset = 1'b1; piso_load = 1'b1;
        tick();
        piso_reset = 1'b0; piso_load = 1'b0;
        chk("e_empty", 32'(empty16), 32'h1);
        chk("e_valid", 32'(valid16), 32'h0);
        tick();
        chk("e_idle_pop_byte", 32'(byte16), 32'h00);
        hold = 1'b1;

`ifndef PISO_CRC_APPEND_EN
        // en_crc is ignored: plain 16-byte frame, no busy, no CRC
        data16 = 128'h000102030405060708090A0B0C0D0E0F;
        load(1'b1);
        chk("f_busy_after_load", 32'(busy16), 32'h0);
        hold = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("f_byte", 32'(byte16), 32'(i));
            chk("f_busy", 32'(busy16), 32'h0);
        end
        chk("f_empty", 32'(empty16), 32'h1);
        chk("f_crc",   32'(crc16),   32'h0);
        tick();
        chk("f_extra_pop_byte", 32'(byte16), 32'h0F);
        hold = 1'b1;
`else
        // "123456789": busy for 9 cycles, CRC 29B1, 11-byte frame
        load(1'b1);
        chk("g_busy_c1", 32'(busy9), 32'h1);
        chk("g_crc_cleared", 32'(crc9), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("g_busy", 32'(busy9), 32'h1);
        end
        tick();
        chk("g_busy_done", 32'(busy9), 32'h0);
        chk("g_crc", 32'(crc9), 32'h29B1);
        hold = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("g_byte", 32'(byte9),
                (i < 9) ? 32'(8'h31 + i) : ((i == 9) ? 32'h29 : 32'hB1));
            chk("g_empty", 32'(empty9), (i == 10) ? 32'h1 : 32'h0);
        end
        hold = 1'b1;

        // Continuous pops from the load cycle
        hold = 1'b0;
        load(1'b1);
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("h_byte", 32'(byte9),
                (i < 9) ? 32'(8'h31 + i) : ((i == 9) ? 32'h29 : 32'hB1));
            if (i == 8) chk("h_busy_drop", 32'(busy9), 32'h0);
        end
        chk("h_empty", 32'(empty9), 32'h1);
        hold = 1'b1;

        // Reload mid-CALC after 5 pops: CRC recomputed from scratch
        load(1'b1);
        hold = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("i_fifth_pop", 32'(byte9), 32'h35);
        load(1'b1);
        chk("i_reload_busy",  32'(busy9),  32'h1);
        chk("i_reload_crc",   32'(crc9),   32'h0);
        chk("i_reload_valid", 32'(valid9), 32'h0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("i_byte", 32'(byte9), 32'(8'h31 + i));
        end
        chk("i_crc", 32'(crc9), 32'h29B1);
        hold = 1'b1;

        // Global reset and PISO_reset during CALC
        load(1'b1);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("j_rst_busy",  32'(busy9),  32'h0);
        chk("j_rst_crc",   32'(crc9),   32'h0);
        chk("j_rst_empty", 32'(empty9), 32'h1);
        chk("j_rst_byte",  32'(byte9),  32'h00);
        load(1'b1);
        tick();
        piso_reset = 1'b1;
        tick();
        piso_reset = 1'b0;
        chk("j_prst_busy",  32'(busy9),  32'h0);
        chk("j_prst_crc",   32'(crc9),   32'h0);
        chk("j_prst_empty", 32'(empty9), 32'h1);
        chk("j_prst_valid", 32'(valid9), 32'h0);
        tick();
        chk("j_prst_stays_idle", 32'(busy9), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
